// File: rtl/test_run_sequencer.sv
// Handshaked sequencer for one hardware test run: arms the write master, streams DUT results into its FIFO, waits for completion.
// Optional TEST_SEQ_AUTO_RESTART_EN: DONE chains straight into GO while start stays high.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for start; all strobes low
// S_GO        | one-cycle control_go pulse, sample counter cleared
// S_CAPTURE   | push one sample per cycle unless the write-master FIFO is full
// S_WAIT_DONE | all samples pushed; waiting for control_done
// S_DONE      | one-cycle run_done pulse, pass counter increments
module test_run_sequencer #(
    parameter int          SAMPLE_WIDTH = 27,
    parameter int          DATAWIDTH    = 32,
    parameter int          ADDRESSWIDTH = 32,
    parameter int          NUM_SAMPLES  = 16382,
    parameter int          COUNT_WIDTH  = 14,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    run_done,
    output logic [15:0]             pass_count,
    output logic                    stim_enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    output logic                    control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] control_write_base,
    output logic [ADDRESSWIDTH-1:0] control_write_length,
    output logic                    control_go,
    input  logic                    control_done,
    output logic                    user_write_buffer,
    output logic [DATAWIDTH-1:0]    user_buffer_data,
    input  logic                    user_buffer_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_CAPTURE,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]  LAST_IDX  = COUNT_WIDTH'(NUM_SAMPLES - 1);
    localparam logic [ADDRESSWIDTH-1:0] WRITE_LEN = ADDRESSWIDTH'(NUM_SAMPLES * (DATAWIDTH / 8));

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [15:0]            pass_q, pass_d;
    logic                   push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pass_d     = pass_q;
        busy       = 1'b1;
        run_done   = 1'b0;
        control_go = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_GO;
            end
            S_GO: begin
                control_go = 1'b1;
                count_d    = '0;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A full FIFO freezes the LFSRs too, so the stalled sample is pushed later, not dropped.
                push = !user_buffer_full;
                if (push) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                    if (count_q == LAST_IDX) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (control_done) state_d = S_DONE;
            end
            S_DONE: begin
                run_done = 1'b1;
                pass_d   = pass_q + 16'd1;
`ifdef TEST_SEQ_AUTO_RESTART_EN
                state_d  = start ? S_GO : S_IDLE;
`else
                state_d  = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stim_enable            = push;
    assign user_write_buffer      = push;
    assign user_buffer_data       = DATAWIDTH'(sample_data);
    assign pass_count             = pass_q;
    assign control_fixed_location = 1'b0;
    assign control_write_base     = ADDRESSWIDTH'(BASE_ADDR);
    assign control_write_length   = WRITE_LEN;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Randomised bench for test_run_sequencer: random sample stream, scenario tasks checked against a run-level model.
module tb_test_run_sequencer;

    localparam int SW   = 27;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NS   = 8;
    localparam int CW   = 4;
    localparam int unsigned BASE = 32'h0000_1000;
`ifdef TEST_SEQ_AUTO_RESTART_EN
    localparam int RESTART_GAP = 1;
`else
    localparam int RESTART_GAP = 2;
`endif

    logic          clk = 1'b0;
    logic          reset, start, control_done, user_buffer_full;
    logic [SW-1:0] sample_data;
    logic          busy, run_done, stim_enable, control_fixed_location, control_go, user_write_buffer;
    logic [15:0]   pass_count;
    logic [AW-1:0] control_write_base, control_write_length;
    logic [DW-1:0] user_buffer_data;

    test_run_sequencer #(
        .SAMPLE_WIDTH(SW), .DATAWIDTH(DW), .ADDRESSWIDTH(AW),
        .NUM_SAMPLES(NS), .COUNT_WIDTH(CW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .run_done(run_done),
        .pass_count(pass_count), .stim_enable(stim_enable), .sample_data(sample_data),
        .control_fixed_location(control_fixed_location), .control_write_base(control_write_base),
        .control_write_length(control_write_length), .control_go(control_go),
        .control_done(control_done), .user_write_buffer(user_write_buffer),
        .user_buffer_data(user_buffer_data), .user_buffer_full(user_buffer_full)
    );

    always #5 clk = ~clk;

    // Stand-in for the LFSR chain: a random table walked by stim_enable.
    logic [SW-1:0] samples [64];
    logic [5:0]    sidx;
    assign sample_data = samples[sidx];

    int            n_tests, n_fail;
    int            cyc, t0, exp_pass;
    int            go_cyc[$], done_cyc[$], push_cyc[$];
    logic [DW-1:0] push_dat[$];
    int            viol, run_pushes, wait_ctr, done_delay;
    bit            done_always;
    logic [5:0]    base;

    task automatic step();
        logic adv;
        @(negedge clk);
        if (user_write_buffer) begin
            push_cyc.push_back(cyc);
            push_dat.push_back(user_buffer_data);
            run_pushes++;
        end
        if (stim_enable !== user_write_buffer) viol++;
        if (user_buffer_full && user_write_buffer) viol++;
        if (control_go) begin
            go_cyc.push_back(cyc);
            run_pushes = 0;
            wait_ctr   = 0;
        end
        if (run_done) done_cyc.push_back(cyc);
        adv = stim_enable;
        @(posedge clk);
        #1;
        cyc++;
        if (adv) sidx = sidx + 6'd1;
        if (run_pushes == NS) wait_ctr++;
        control_done = done_always || (run_pushes == NS && wait_ctr >= done_delay);
    endtask

    task automatic clear_logs();
        go_cyc.delete(); done_cyc.delete(); push_cyc.delete(); push_dat.delete();
        viol = 0; run_pushes = 0; wait_ctr = 0;
        t0   = cyc;
        base = sidx;
    endtask

    function automatic int data_errs(input logic [5:0] b);
        int errs = 0;
        for (int k = 0; k < push_dat.size(); k++)
            if (push_dat[k] !== DW'(samples[b + 6'(k)])) errs++;
        return errs;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -999;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; user_buffer_full = 1'b0; control_done = 1'b0;
        done_always = 1'b0; done_delay = 3;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (pass_count !== 16'd0) begin n_fail++; $display("FAIL reset_pass got %0d want 0", pass_count); end
        n_tests++; if ({run_done, stim_enable, control_go, user_write_buffer} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b want 0000", {run_done, stim_enable, control_go, user_write_buffer}); end
        reset = 1'b0;
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b want 0", busy); end
        n_tests++; if (control_fixed_location !== 1'b0) begin n_fail++; $display("FAIL fixed_loc got %0b want 0", control_fixed_location); end
        n_tests++; if (control_write_base !== AW'(BASE)) begin n_fail++; $display("FAIL write_base got %h want %h", control_write_base, BASE); end
        n_tests++; if (control_write_length !== AW'(NS * DW / 8)) begin n_fail++; $display("FAIL write_len got %0d want %0d", control_write_length, NS * DW / 8); end
        n_tests++; if (user_buffer_data !== {{(DW-SW){1'b0}}, samples[sidx]}) begin
            n_fail++; $display("FAIL zero_ext got %h want %h", user_buffer_data, {{(DW-SW){1'b0}}, samples[sidx]}); end
        n_tests++; if (go_cyc.size() != 0 || viol != 0) begin n_fail++; $display("FAIL idle_quiet got go=%0d viol=%0d want 0 0", go_cyc.size(), viol); end
    endtask

    task automatic test_basic_run();
        clear_logs();
        done_delay = 3;
        start = 1'b1; step(); start = 1'b0;
        repeat (30) step();
        exp_pass++;
        n_tests++; if (go_cyc.size() != 1 || q_at(go_cyc, 0) - t0 != 1) begin
            n_fail++; $display("FAIL basic_go got n=%0d at=%0d want 1 at 1", go_cyc.size(), q_at(go_cyc, 0) - t0); end
        n_tests++; if (push_cyc.size() != NS) begin n_fail++; $display("FAIL basic_pushes got %0d want %0d", push_cyc.size(), NS); end
        n_tests++; if (q_at(push_cyc, 0) - t0 != 2 || q_at(push_cyc, NS-1) - q_at(push_cyc, 0) != NS-1) begin
            n_fail++; $display("FAIL basic_push_timing got first=%0d span=%0d want 2 %0d", q_at(push_cyc, 0) - t0, q_at(push_cyc, NS-1) - q_at(push_cyc, 0), NS-1); end
        n_tests++; if (data_errs(base) != 0) begin n_fail++; $display("FAIL basic_data got %0d bad words want 0", data_errs(base)); end
        n_tests++; if (done_cyc.size() != 1 || q_at(done_cyc, 0) - t0 != 2 + NS + done_delay) begin
            n_fail++; $display("FAIL basic_done got n=%0d at=%0d want 1 at %0d", done_cyc.size(), q_at(done_cyc, 0) - t0, 2 + NS + done_delay); end
        n_tests++; if (pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL basic_pass got %0d want %0d", pass_count, exp_pass); end
        n_tests++; if (viol != 0) begin n_fail++; $display("FAIL basic_strobe got %0d want 0", viol); end
    endtask

    task automatic test_full_stall();
        int stall_at;
        clear_logs();
        stall_at = $urandom_range(3, 7);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i < 40; i++) begin
            user_buffer_full = (i >= stall_at && i < stall_at + 5);
            step();
        end
        user_buffer_full = 1'b0;
        exp_pass++;
        n_tests++; if (push_cyc.size() != NS) begin n_fail++; $display("FAIL stall_pushes got %0d want %0d", push_cyc.size(), NS); end
        n_tests++; if (q_at(push_cyc, NS-1) - q_at(push_cyc, 0) != NS - 1 + 5) begin
            n_fail++; $display("FAIL stall_span got %0d want %0d", q_at(push_cyc, NS-1) - q_at(push_cyc, 0), NS + 4); end
        n_tests++; if (data_errs(base) != 0 || viol != 0) begin
            n_fail++; $display("FAIL stall_data got bad=%0d viol=%0d want 0 0", data_errs(base), viol); end
        n_tests++; if (pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL stall_pass got %0d want %0d", pass_count, exp_pass); end
    endtask

    task automatic test_full_last();
        clear_logs();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i < 30; i++) begin
            user_buffer_full = (i == NS + 1 || i == NS + 2);
            step();
        end
        user_buffer_full = 1'b0;
        exp_pass++;
        n_tests++; if (push_cyc.size() != NS || q_at(push_cyc, NS-1) - t0 != NS + 3) begin
            n_fail++; $display("FAIL last_retry got n=%0d at=%0d want %0d at %0d", push_cyc.size(), q_at(push_cyc, NS-1) - t0, NS, NS + 3); end
        n_tests++; if (data_errs(base) != 0 || viol != 0) begin
            n_fail++; $display("FAIL last_data got bad=%0d viol=%0d want 0 0", data_errs(base), viol); end
    endtask

    task automatic test_start_toggle();
        clear_logs();
        done_delay = 4;
        start = 1'b1; step();
        for (int i = 1; i < 40; i++) begin
            start = (i <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        exp_pass++;
        n_tests++; if (go_cyc.size() != 1 || done_cyc.size() != 1) begin
            n_fail++; $display("FAIL toggle_runs got go=%0d done=%0d want 1 1", go_cyc.size(), done_cyc.size()); end
        n_tests++; if (pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL toggle_pass got %0d want %0d", pass_count, exp_pass); end
        done_delay = 3;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 20 && push_cyc.size() < 4; i++) step();
        n_tests++; if (busy !== 1'b1 || push_cyc.size() != 4) begin
            n_fail++; $display("FAIL midrst_pre got busy=%0b n=%0d want 1 4", busy, push_cyc.size()); end
        reset = 1'b1;
        #1;
        exp_pass = 0;
        n_tests++; if ({busy, stim_enable, user_write_buffer, control_go, run_done} !== 5'b0 || pass_count !== 16'd0) begin
            n_fail++; $display("FAIL midrst_async got %b pass=%0d want 00000 0",
                               {busy, stim_enable, user_write_buffer, control_go, run_done}, pass_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_logs();
        start = 1'b1; step(); start = 1'b0;
        repeat (30) step();
        exp_pass++;
        n_tests++; if (push_cyc.size() != NS || data_errs(base) != 0) begin
            n_fail++; $display("FAIL midrst_rerun got n=%0d bad=%0d want %0d 0", push_cyc.size(), data_errs(base), NS); end
        n_tests++; if (pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL midrst_pass got %0d want %0d", pass_count, exp_pass); end
    endtask

    task automatic test_done_high();
        clear_logs();
        done_always = 1'b1;
        control_done = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        repeat (25) step();
        done_always = 1'b0;
        exp_pass++;
        n_tests++; if (push_cyc.size() != NS) begin n_fail++; $display("FAIL donehi_pushes got %0d want %0d", push_cyc.size(), NS); end
        n_tests++; if (done_cyc.size() != 1 || q_at(done_cyc, 0) - t0 != NS + 3) begin
            n_fail++; $display("FAIL donehi_exit got n=%0d at=%0d want 1 at %0d", done_cyc.size(), q_at(done_cyc, 0) - t0, NS + 3); end
    endtask

    task automatic test_back_to_back();
        int gap_bad, len_bad;
        clear_logs();
        start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (go_cyc.size() >= 3) start = 1'b0;
        end
        exp_pass += 3;
        gap_bad = 0; len_bad = 0;
        for (int r = 0; r < 3; r++) begin
            if (q_at(done_cyc, r) - q_at(go_cyc, r) != 1 + NS + done_delay) len_bad++;
            if (r < 2 && q_at(go_cyc, r + 1) - q_at(done_cyc, r) != RESTART_GAP) gap_bad++;
        end
        n_tests++; if (go_cyc.size() != 3 || done_cyc.size() != 3) begin
            n_fail++; $display("FAIL b2b_runs got go=%0d done=%0d want 3 3", go_cyc.size(), done_cyc.size()); end
        n_tests++; if (gap_bad != 0 || len_bad != 0) begin
            n_fail++; $display("FAIL b2b_timing got gap_bad=%0d len_bad=%0d want 0 0", gap_bad, len_bad); end
        n_tests++; if (push_cyc.size() != 3 * NS || data_errs(base) != 0) begin
            n_fail++; $display("FAIL b2b_data got n=%0d bad=%0d want %0d 0", push_cyc.size(), data_errs(base), 3 * NS); end
        n_tests++; if (pass_count !== 16'(exp_pass)) begin n_fail++; $display("FAIL b2b_pass got %0d want %0d", pass_count, exp_pass); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; exp_pass = 0; sidx = '0;
        for (int i = 0; i < 64; i++) samples[i] = SW'($urandom);
        test_reset();
        test_basic_run();
        test_full_stall();
        test_full_last();
        test_start_toggle();
        test_reset_mid();
        test_done_high();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
